pulse_source: RTL and testbench

Stimulus generator for the two-channel event counter. On a start command it latches two target counts and drives the counter's `En`/`Slt` inputs with a burst of single-cycle events. The result is channel 0 advanced by exactly `Count0` and channel 1's divided output advanced by exactly `Count1`. It sits upstream of the counter, in the same clock domain, and serves as the transmit end of the `En`/`Slt` event interface.

---
 rtl/pulse_source.sv | 108 ++++++++++
 tb/tb_pulse_source.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_source.sv
// Burst generator for the two-channel event counter: emits Count0 channel-0
// events followed by DIV*Count1 channel-1 events on the En/Slt interface.
module pulse_source #(
   parameter int WIDTH = 64,
   parameter int DIV   = 4
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic             Pause,
   input  logic [WIDTH-1:0] Count0,
   input  logic [WIDTH-1:0] Count1,
   output logic             En,
   output logic             Slt,
   output logic             Busy,
   output logic             Done
);

   localparam int REMW = WIDTH + $clog2(DIV);

   typedef enum logic [1:0] {S_IDLE, S_RUN0, S_RUN1, S_DONE} state_t;

   state_t            r_state, w_state_nxt;
   logic [REMW-1:0]   r_rem, w_rem_nxt;
   logic [WIDTH-1:0]  r_c1, w_c1_nxt;
   logic              r_en, w_en_nxt;
   logic              r_slt, w_slt_nxt;
   logic [WIDTH-1:0]  w_mul_src;
   logic [REMW-1:0]   w_mul;

   // One scaler serves both the Start path (Count1) and the RUN0->RUN1 handoff (c1).
   assign w_mul_src = (r_state == S_IDLE) ? Count1 : r_c1;
   assign w_mul     = REMW'(w_mul_src) * REMW'(DIV);

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_state <= S_IDLE;
         r_rem   <= '0;
         r_c1    <= '0;
         r_en    <= 1'b0;
         r_slt   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_rem   <= w_rem_nxt;
         r_c1    <= w_c1_nxt;
         r_en    <= w_en_nxt;
         r_slt   <= w_slt_nxt;
      end
   end

   // RUN1 with rem==0 is a one-cycle drain: it covers the last En cycle (so Busy
   // stays high over it) and gives the zero-count burst its one-cycle Done latency.
   always_comb begin
      w_state_nxt = r_state;
      w_rem_nxt   = r_rem;
      w_c1_nxt    = r_c1;
      w_en_nxt    = 1'b0;
      w_slt_nxt   = r_slt;
      case (r_state)
         S_IDLE: begin
            if (Start) begin
               w_c1_nxt = Count1;
               if (Count0 != '0) begin
                  w_state_nxt = S_RUN0;
                  w_rem_nxt   = REMW'(Count0);
               end else begin
                  w_state_nxt = S_RUN1;
                  w_rem_nxt   = w_mul;
               end
            end
         end
         S_RUN0: begin
            if (!Pause) begin
               w_en_nxt  = 1'b1;
               w_slt_nxt = 1'b0;
               if (r_rem == REMW'(1)) begin
                  w_state_nxt = S_RUN1;
                  w_rem_nxt   = w_mul;
               end else begin
                  w_rem_nxt = r_rem - REMW'(1);
               end
            end
         end
         S_RUN1: begin
            if (r_rem == '0) begin
               w_state_nxt = S_DONE;
            end else if (!Pause) begin
               w_en_nxt  = 1'b1;
               w_slt_nxt = 1'b1;
               w_rem_nxt = r_rem - REMW'(1);
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign En   = r_en;
   assign Slt  = r_slt;
   assign Busy = (r_state == S_RUN0) ||
                 ((r_state == S_RUN1) && ((r_rem != '0) || r_en));
   assign Done = (r_state == S_DONE);

endmodule

// File: tb/tb_pulse_source.sv
// Scoreboard bench for pulse_source: expected Slt per event is queued at Start
// and popped on every observed En; burst timing is checked per scenario.
module tb_pulse_source;

   localparam int WIDTH = 16;
   localparam int DIV   = 4;

   logic             Clk = 1'b0;
   logic             Reset, Start, Pause;
   logic [WIDTH-1:0] Count0, Count1;
   logic             En, Slt, Busy, Done;

   int total = 0;
   int bad   = 0;
   bit sb[$];

   pulse_source #(.WIDTH(WIDTH), .DIV(DIV)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Pause(Pause),
      .Count0(Count0), .Count1(Count1),
      .En(En), .Slt(Slt), .Busy(Busy), .Done(Done)
   );

   always #5 Clk = ~Clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic start_burst(input int c0, input int c1);
      Start  = 1'b1;
      Count0 = WIDTH'(c0);
      Count1 = WIDTH'(c1);
      for (int i = 0; i < c0; i++) sb.push_back(1'b0);
      for (int i = 0; i < c1 * DIV; i++) sb.push_back(1'b1);
      @(posedge Clk);
      #1;
      Start  = 1'b0;
      Count0 = WIDTH'($urandom());
      Count1 = WIDTH'($urandom());
   endtask

   // Samples once per cycle from the accept cycle (index 0) until Done.
   task automatic collect(input int n_ev, input int pause_after, input int pause_len,
                          input bit inj_run, input bit inj_done,
                          output int done_idx, output int ev0, output int ev1,
                          output int first, output int last, output int busy_err);
      int pl;
      bit exp_slt;
      pl = 0; done_idx = -1; ev0 = 0; ev1 = 0; first = -1; last = -1; busy_err = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge Clk);
         if (En) begin
            total++;
            if (sb.size() == 0) begin
               bad++;
               $display("FAIL sb_extra: En at sample %0d, expected no event", i);
            end else begin
               exp_slt = sb.pop_front();
               if (Slt !== exp_slt) begin
                  bad++;
                  $display("FAIL sb_slt: event %0d Slt=%b expected %b", ev0 + ev1, Slt, exp_slt);
               end
            end
            if (Slt) ev1++; else ev0++;
            if (first < 0) first = i;
            last = i;
         end
         if (Done) begin
            if (Busy !== 1'b0 || En !== 1'b0) busy_err++;
            done_idx = i;
            if (inj_done) begin
               Start = 1'b1; Count0 = 7; Count1 = 7;
               @(posedge Clk);
               #1;
               Start = 1'b0;
            end
            break;
         end else if (Busy !== (n_ev > 0)) begin
            busy_err++;
         end
         if (En && pause_len > 0 && (ev0 + ev1) == pause_after) begin
            Pause = 1'b1;
            pl = pause_len;
         end else if (pl > 0) begin
            pl--;
            if (pl == 0) Pause = 1'b0;
         end
         if (inj_run && i == 1) begin Start = 1'b1; Count0 = 9; Count1 = 9; end
         if (inj_run && i == 2) Start = 1'b0;
      end
      if (done_idx < 0) begin
         total++; bad++;
         $display("FAIL collect_timeout: no Done within budget");
      end
   endtask

   task automatic check_burst(input string name, input int done_idx, input int exp_done,
                              input int ev0, input int exp0, input int ev1, input int exp1,
                              input int first, input int last, input int exp_gap, input int busy_err);
      total++;
      if (done_idx !== exp_done) begin bad++; $display("FAIL %s_done_idx: got %0d expected %0d", name, done_idx, exp_done); end
      total++;
      if (ev0 !== exp0) begin bad++; $display("FAIL %s_ev0: got %0d expected %0d", name, ev0, exp0); end
      total++;
      if (ev1 !== exp1) begin bad++; $display("FAIL %s_ev1: got %0d expected %0d", name, ev1, exp1); end
      if (exp0 + exp1 > 0) begin
         total++;
         if ((last - first + 1 - ev0 - ev1) !== exp_gap || first !== 1) begin
            bad++;
            $display("FAIL %s_contig: first=%0d last=%0d events=%0d expected first=1 gap=%0d", name, first, last, ev0 + ev1, exp_gap);
         end
      end
      total++;
      if (busy_err !== 0) begin bad++; $display("FAIL %s_busy: %0d bad Busy samples expected 0", name, busy_err); end
      total++;
      if (sb.size() !== 0) begin bad++; $display("FAIL %s_sb_left: %0d events missing expected 0", name, sb.size()); end
      sb.delete();
   endtask

   task automatic test_reset();
      int err;
      err = 0;
      Reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         Start = 1'($urandom_range(0, 1)); Pause = 1'($urandom_range(0, 1));
         Count0 = WIDTH'($urandom()); Count1 = WIDTH'($urandom());
         @(negedge Clk);
         if ({En, Slt, Busy, Done} !== 4'b0000) err++;
      end
      total++;
      if (err !== 0) begin bad++; $display("FAIL reset_hold: %0d nonzero output samples expected 0", err); end
      Start = 1'b0; Pause = 1'b0;
      Reset = 1'b1;
      err = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge Clk);
         if ({En, Slt, Busy, Done} !== 4'b0000) err++;
      end
      total++;
      if (err !== 0) begin bad++; $display("FAIL reset_idle: %0d activity samples without Start expected 0", err); end
   endtask

   task automatic test_basic();
      int d, e0, e1, f, l, be, err;
      start_burst(3, 2);
      collect(11, 0, 0, 1'b0, 1'b0, d, e0, e1, f, l, be);
      check_burst("basic", d, 12, e0, 3, e1, 8, f, l, 0, be);
      total++;
      if (e1 / DIV !== 2 || e1 % DIV !== 0) begin bad++; $display("FAIL basic_counter1: Output1=%0d expected 2", e1 / DIV); end
      err = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge Clk);
         if (Done !== 1'b0 || En !== 1'b0) err++;
      end
      total++;
      if (err !== 0) begin bad++; $display("FAIL basic_single_done: %0d extra Done/En samples expected 0", err); end
   endtask

   task automatic test_zero();
      int d, e0, e1, f, l, be;
      tick();
      start_burst(0, 0);
      collect(0, 0, 0, 1'b0, 1'b0, d, e0, e1, f, l, be);
      check_burst("zero00", d, 1, e0, 0, e1, 0, f, l, 0, be);
      tick();
      start_burst(0, 1);
      collect(4, 0, 0, 1'b0, 1'b0, d, e0, e1, f, l, be);
      check_burst("zero01", d, 5, e0, 0, e1, 4, f, l, 0, be);
   endtask

   task automatic test_pause();
      int d, e0, e1, f, l, be;
      tick();
      start_burst(5, 0);
      collect(5, 2, 3, 1'b0, 1'b0, d, e0, e1, f, l, be);
      check_burst("pause", d, 9, e0, 5, e1, 0, f, l, 3, be);
   endtask

   task automatic test_start_busy();
      int d, e0, e1, f, l, be, err;
      tick();
      start_burst(4, 1);
      collect(8, 0, 0, 1'b1, 1'b1, d, e0, e1, f, l, be);
      check_burst("startbusy", d, 9, e0, 4, e1, 4, f, l, 0, be);
      err = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge Clk);
         if ({En, Busy, Done} !== 3'b000) err++;
      end
      total++;
      if (err !== 0) begin bad++; $display("FAIL startbusy_ignored: %0d active samples after burst expected 0", err); end
   endtask

   task automatic test_async_reset();
      int d, e0, e1, f, l, be, n, err;
      bit exp_slt;
      tick();
      start_burst(2, 3);
      n = 0;
      for (int i = 0; i < 40 && n < 4; i++) begin
         @(negedge Clk);
         if (En) begin
            exp_slt = sb.pop_front();
            total++;
            if (Slt !== exp_slt) begin bad++; $display("FAIL areset_slt: event %0d Slt=%b expected %b", n, Slt, exp_slt); end
            n++;
         end
      end
      #2;
      Reset = 1'b0;
      #1;
      total++;
      if (En !== 1'b0 || Busy !== 1'b0) begin bad++; $display("FAIL areset_immediate: En=%b Busy=%b expected 0 0", En, Busy); end
      sb.delete();
      err = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge Clk);
         if ({En, Busy, Done} !== 3'b000) err++;
      end
      Reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge Clk);
         if ({En, Busy, Done} !== 3'b000) err++;
      end
      total++;
      if (err !== 0) begin bad++; $display("FAIL areset_no_done: %0d active samples expected 0", err); end
      tick();
      start_burst(1, 1);
      collect(5, 0, 0, 1'b0, 1'b0, d, e0, e1, f, l, be);
      check_burst("areset_after", d, 6, e0, 1, e1, 4, f, l, 0, be);
   endtask

   initial begin
      Reset = 1'b0; Start = 1'b0; Pause = 1'b0; Count0 = '0; Count1 = '0;
      test_reset();
      tick();
      test_basic();
      test_zero();
      test_pause();
      test_start_busy();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
